zero_sequence_counter: RTL and testbench
========================================

Name: zero_sequence_counter

Overview:
Serial zero-run detector. Each clock it samples a 1-bit serial input and reports, on a 4-bit registered output, the length of the current run of consecutive 0 samples. The count saturates and is cleared by any 1 sample. It is a leaf block used as a building block and bring-up example in the team's module library.

Parameters:
CNT_W, 4, width of the run-length output. The bench and default build use 4.
CNT_MAX, 2**CNT_W-1 (15), saturation value. Derived from CNT_W; not independently overridable.

Ports:
clk  input  1  single system clock; all state updates on the rising edge
NOT_RESET  input  1  synchronous, active-high reset. The legacy port name is kept for bench compatibility; a value of 1 means reset.
ENABLE  input  1  serial data bit sampled every rising edge; 0 extends the zero run and 1 terminates it
out  output  CNT_W  registered length of the current zero run

Behaviour:
- Single register cnt[CNT_W-1:0] drives out directly. No combinational path from inputs to out.
- Reset:
  - At a rising edge with NOT_RESET=1, cnt <= 0.
  - Reset has priority over ENABLE.
  - A one-cycle assertion is sufficient.
  - Reset mid-run clears the count immediately at that edge.
- Normal operation, at a rising edge with NOT_RESET=0:
  - ENABLE=1: cnt <= 0.
  - ENABLE=0 and cnt < CNT_MAX: cnt <= cnt + 1.
  - ENABLE=0 and cnt == CNT_MAX: cnt holds at CNT_MAX. It saturates and never wraps to 0.
- Latency: one cycle. out after edge k reflects ENABLE sampled at edges up to and including k.
- Run boundary: a single 0 between 1s yields out=1 for exactly one cycle, then 0.
- Before the first reset, out is undefined (X in simulation). No power-on value is required.
- If ENABLE is X/Z while reset is deasserted, out is unspecified until the next reset or the next known ENABLE=1. Benches must drive ENABLE to a known value after reset before checking out.
- No other state; no FSM beyond the saturating counter.
- Arithmetic is unsigned, CNT_W bits; the increment is computed in CNT_W+1 bits or compared against CNT_MAX, so overflow cannot occur.

Decomposition:
- Package zero_seq_pkg holds:
  - localparam CNT_W = 4
  - localparam CNT_MAX
  - typedef logic [CNT_W-1:0] run_len_t, used for out and cnt
- One natural sub-module: sat_up_counter, with sync clear, increment enable and saturation at CNT_MAX. The top instantiates it with:
  - clear = NOT_RESET | ENABLE
  - inc = ~ENABLE
- The top also holds the parameter checks (CNT_W >= 1) and SVA properties:
  - out never exceeds CNT_MAX.
  - out increments by at most 1 per cycle.
  - ENABLE=1 at an edge implies out==0 after that edge.

Test Plan:
- Reset: drive NOT_RESET=1 for one clock from the X state -> out=0 after that edge. Release and drive ENABLE=1 -> out stays 0.
- Ones pattern: ENABLE=1 for 4 cycles -> out=0 throughout.
- Isolated zero: ENABLE=0 for 1 cycle, then ENABLE=1 for 2 cycles -> out sequence 1, 0, 0.
- Long zero run and saturation: hold ENABLE=0 for 20 cycles -> out = 1, 2, ..., 15, then holds 15 for the remaining cycles with no wrap. A following ENABLE=1 -> out=0.
- Reset mid-run: with out=7 and ENABLE=0, assert NOT_RESET=1 for one cycle -> out=0 at that edge. After release with ENABLE=0 -> out=1 next edge.
- Priority: NOT_RESET=1 and ENABLE=0 together for 3 cycles -> out stays 0. Then random ENABLE for 1000 cycles -> out matches the reference model, with the SVA properties holding.

Source files
------------

// File: rtl/zero_seq_pkg.sv
// Shared widths and types for the serial zero-run detector.
package zero_seq_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] run_len_t;

  localparam run_len_t CNT_MAX = run_len_t'((1 << CNT_W) - 1);

endpackage : zero_seq_pkg

// File: rtl/sat_up_counter.sv
// Up counter with synchronous clear and saturation at a configurable ceiling.
module sat_up_counter #(
  parameter int            W   = 4,
  parameter logic [W-1:0]  MAX = '1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] countReg;

  // Clear wins; otherwise step up until the ceiling is reached, then hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      countReg <= '0;
    end else if (inc && (countReg != MAX)) begin
      countReg <= countReg + ONE;
    end else begin
      countReg <= countReg;
    end
  end

  assign count = countReg;

endmodule : sat_up_counter

// File: rtl/zero_sequence_counter.sv
// Serial zero-run detector: out is the saturating length of the current run
// of 0 samples on ENABLE, cleared by any 1 sample or by NOT_RESET.
module zero_sequence_counter
  import zero_seq_pkg::*;
(
  input  logic     clk,
  input  logic     NOT_RESET,
  input  logic     ENABLE,
  output run_len_t out
);

  generate
    if (CNT_W < 1) begin : gBadWidth
      $error("zero_sequence_counter: CNT_W must be at least 1");
    end
  endgenerate

  logic clearCnt;
  logic incCnt;

  // NOT_RESET is an active-high reset despite its legacy name.
  assign clearCnt = NOT_RESET | ENABLE;
  assign incCnt   = ~ENABLE;

  sat_up_counter #(
    .W   (CNT_W),
    .MAX (CNT_MAX)
  ) uCounter (
    .clk   (clk),
    .clear (clearCnt),
    .inc   (incCnt),
    .count (out)
  );

  aOutBounded : assert property (@(posedge clk)
    !$isunknown(out) |-> (out <= CNT_MAX));

  aStepAtMostOne : assert property (@(posedge clk)
    (!$isunknown($past(out)) && !$isunknown(out))
      |-> ({1'b0, out} <= ({1'b0, $past(out)} + {{CNT_W{1'b0}}, 1'b1})));

  aOneClears : assert property (@(posedge clk)
    (ENABLE === 1'b1) |=> (out == '0));

endmodule : zero_sequence_counter

// File: tb/tb_zero_sequence_counter.sv
// Scoreboard bench for zero_sequence_counter: directed vectors plus a random
// phase checked against a small reference model.
module tb_zero_sequence_counter;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } item_t;

  logic       clk;
  logic       NOT_RESET;
  logic       ENABLE;
  logic [3:0] out;

  item_t expQ[$];
  int    checks;
  int    errors;
  logic  stimDone;

  zero_sequence_counter dut (
    .clk       (clk),
    .NOT_RESET (NOT_RESET),
    .ENABLE    (ENABLE),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the value out must
  // show after the next rising edge.
  task automatic step(input logic rst, input logic en, input logic [3:0] exp,
                      input string name);
    item_t it;
    @(negedge clk);
    NOT_RESET = rst;
    ENABLE    = en;
    it.exp    = exp;
    it.name   = name;
    expQ.push_back(it);
  endtask

  // Monitor: compare out shortly after every rising edge that has a pending expectation.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        it = expQ.pop_front();
        checks++;
        if (out !== it.exp) begin
          errors++;
          $display("FAIL %s: out=%0d expected=%0d at t=%0t", it.name, out, it.exp, $time);
        end
      end
    end
  end

  initial begin
    logic [3:0] model;
    logic       en;
    int         waitCycles;
    checks    = 0;
    errors    = 0;
    stimDone  = 1'b0;
    NOT_RESET = 1'b0;
    ENABLE    = 1'b0;

    // Reset from the unknown state, then release with ENABLE high.
    step(1'b1, 1'b0, 4'd0, "reset");
    step(1'b0, 1'b1, 4'd0, "release_one");

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd0, "ones");

    step(1'b0, 1'b0, 4'd1, "isolated_zero");
    step(1'b0, 1'b1, 4'd0, "isolated_one_a");
    step(1'b0, 1'b1, 4'd0, "isolated_one_b");

    // Long run: 1..15 then stuck at 15, never wrapping.
    for (int i = 1; i <= 20; i++)
      step(1'b0, 1'b0, (i < 15) ? 4'(i) : 4'd15, (i < 15) ? "long_run" : "saturate");
    step(1'b0, 1'b1, 4'd0, "clear_after_sat");

    for (int i = 1; i <= 7; i++) step(1'b0, 1'b0, 4'(i), "run_to_7");
    step(1'b1, 1'b0, 4'd0, "reset_mid_run");
    step(1'b0, 1'b0, 4'd1, "after_mid_reset");

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, "reset_priority");

    // Random phase, ones kept rare so saturation is reached regularly.
    model = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      en = ($urandom_range(0, 7) == 0);
      if (en) model = 4'd0;
      else if (model != 4'd15) model = model + 4'd1;
      step(1'b0, en, model, "random");
    end
    stimDone = 1'b1;

    waitCycles = 0;
    while ((expQ.size() > 0) && (waitCycles < 10)) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: pending=%0d expected=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_zero_sequence_counter
